fp_minmax_reduce: RTL
=====================

Name: fp_minmax_reduce

Overview:
- Streaming min/max reduction unit for single and double precision.
- Consumes beats of LANES IEEE-754 operands under valid/ready, with a per-lane mask, and reduces them into one running result with RISC-V fmin/fmax NaN semantics.
- On the last beat it emits the extremum, its element index (arg-min/arg-max) and accumulated flags.
- Sits beside the scalar FP unit and serves vector/reduction instructions.

Parameters:
- LANES, 4, operands per beat (power of two, ≥1)
- IDXW, 16, width of the element index/counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  64*LANES  lane i = bits [64i+63:64i]
- in_mask  in  LANES  lane enable; a masked lane is ignored
- in_last  in  1  final beat of reduction
- in_fmt  in  1  0 = single (lane low 32 bits), 1 = double
- in_op  in  1  0 = min, 1 = max
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_result  out  64  result; single format has upper 32 bits zero
- out_index  out  IDXW  element index of result; all-ones if result is canonical NaN
- out_flags  out  5  {NV,DZ,OF,UF,NX}; only NV (bit 4) is ever set

Behaviour:
- Reset, asynchronous while low:
  - Outputs: out_valid=0, out_result=0, out_index=0, out_flags=0.
  - State: state=IDLE, accumulator empty, beat counter 0, sticky NV=0.
  - Reset mid-reduction discards the partial result.
- States:
  - IDLE: no beat accepted yet. An accepted beat with in_last=0 goes to ACC; with in_last=1 goes to DONE.
  - ACC: accepted beat with in_last=1 goes to DONE; otherwise stays in ACC.
  - DONE: out_valid=1. On out_ready, go to IDLE, unless a beat is accepted in the same cycle; then go to ACC or DONE per that beat's in_last.
- in_ready = (state != DONE) | out_ready. A new reduction may start in the cycle the previous result drains.
- in_fmt and in_op are sampled on the first beat and held internally; later beats' values are ignored.
- Latency: out_valid rises the cycle after the in_last beat is accepted. The result is registered and held stable until out_ready.
- Element index = beat_count*LANES + lane. beat_count increments per accepted beat and saturates at all-ones; indices clamp to all-ones.
- Comparison, per pair, combinational (fp_mm_cmp):
  - sNaN operand sets sticky NV.
  - A NaN (q or s) loses to any non-NaN.
  - Two NaNs give canonical NaN: 0x7FC00000 for single, 0x7FF8000000000000 for double.
  - Otherwise order by sign-magnitude, with -0 < +0.
  - Equal bit patterns: the lower index wins.
- Per beat:
  - A log2(LANES)-level tree reduces the enabled lanes. On ties, the left operand (lower lane) is taken.
  - The beat result is then combined with the accumulator, accumulator as the left operand.
  - A beat with in_mask=0 changes nothing except the beat counter.
- Empty reduction (every lane masked for the whole reduction): out_result = canonical NaN, out_index = all-ones, NV as accumulated (0).
- Single format: the compare uses lane[31:0] only; upper bits are ignored and not NaN-box checked.
- out_flags = {sticky NV, 4'b0}. Sticky NV clears when a new reduction starts.

Decomposition:
- fp_wire package additions:
  - constants FP_CNAN_S = 64'h000000007fc00000 and FP_CNAN_D = 64'h7ff8000000000000;
  - enum fp_mmr_state_t {IDLE, ACC, DONE};
  - struct fp_mm_cmp_in_type / fp_mm_cmp_out_type with fields a, b, idx_a, idx_b, fmt, op, a_valid, b_valid → res, idx, valid, nv.
- Sub-module fp_mm_cmp: combinational two-operand select.
  - Instantiated LANES-1 times for the tree, plus once for the accumulator merge.
  - valid=0 on both inputs gives an invalid output.

Test Plan:
- Single max, one beat [0x3F800000, 0x40000000, 0xBF800000, 0x3F800000], mask 1111, last → result 0x0000000040000000, index 1, flags 0, one cycle later.
- Single min [0x00000000, 0x80000000, 0x7FC00000, 0x3F800000] → result 0x80000000 (-0 < +0), index 1, flags 0.
- Double min over 3 beats; sNaN 0x7FF0000000000001 in beat 0 lane 2; 1.0 = 0x3FF0000000000000 in beat 2 lane 3; all else 2.0 → result 0x3FF0000000000000, index 11, flags 5'b10000.
- Masks: beat 0 all-NaN, beat 1 mask 0000, last → canonical NaN 0x000000007fc00000, index all-ones, flags 0.
- Back-pressure: out_ready held 0 for 5 cycles → in_ready=0 and result stable. Assert out_ready with a new first beat in the same cycle → that beat is accepted and the old result drains.
- Reset pulsed low mid-ACC (async, between edges) → outputs 0 immediately. The next reduction of [5.0] alone returns 0x40A00000, index 0.

Source files
------------

// File: rtl/fp_wire.sv
// rtl/fp_wire.sv - shared types, constants and helpers for the FP min/max reduction
package fp_wire;

  localparam logic [63:0] FP_CNAN_S = 64'h000000007fc00000;
  localparam logic [63:0] FP_CNAN_D = 64'h7ff8000000000000;

  // Index fields are carried at this width; the reduction top truncates to its IDXW.
  localparam int FP_MM_IDX_W = 32;

  typedef enum logic [1:0] {IDLE, ACC, DONE} fp_mmr_state_t;

  typedef struct packed {
    logic [63:0]            a;
    logic [63:0]            b;
    logic [FP_MM_IDX_W-1:0] idx_a;
    logic [FP_MM_IDX_W-1:0] idx_b;
    logic                   fmt;
    logic                   op;
    logic                   a_valid;
    logic                   b_valid;
  } fp_mm_cmp_in_type;

  typedef struct packed {
    logic [63:0]            res;
    logic [FP_MM_IDX_W-1:0] idx;
    logic                   valid;
    logic                   nv;
  } fp_mm_cmp_out_type;

  function automatic logic fp_is_nan(input logic [63:0] x, input logic fmt);
    return fmt ? ((&x[62:52]) & (|x[51:0])) : ((&x[30:23]) & (|x[22:0]));
  endfunction

  function automatic logic fp_is_snan(input logic [63:0] x, input logic fmt);
    return fp_is_nan(x, fmt) & ~(fmt ? x[51] : x[22]);
  endfunction

  // Maps sign-magnitude to an unsigned key so that -0 sorts just below +0.
  function automatic logic [63:0] fp_order_key(input logic [63:0] x, input logic fmt);
    logic [63:0] k;
    if (fmt) k = x[63] ? ~x : {1'b1, x[62:0]};
    else     k = {32'b0, (x[31] ? ~x[31:0] : {1'b1, x[30:0]})};
    return k;
  endfunction

  function automatic logic [63:0] fp_cnan(input logic fmt);
    return fmt ? FP_CNAN_D : FP_CNAN_S;
  endfunction

endpackage

// File: rtl/fp_mm_cmp.sv
// rtl/fp_mm_cmp.sv - combinational two-operand min/max select with RISC-V NaN rules
module fp_mm_cmp
  import fp_wire::*;
(
  input  fp_mm_cmp_in_type  cmp_i,
  output fp_mm_cmp_out_type cmp_o
);

  logic        a_nan, b_nan, a_snan, b_snan;
  logic        b_wins, both_nan, sel_nan;
  logic [63:0] key_a, key_b, sel_res;
  logic [FP_MM_IDX_W-1:0] sel_idx;

  always_comb begin
    a_nan    = fp_is_nan(cmp_i.a, cmp_i.fmt);
    b_nan    = fp_is_nan(cmp_i.b, cmp_i.fmt);
    a_snan   = fp_is_snan(cmp_i.a, cmp_i.fmt);
    b_snan   = fp_is_snan(cmp_i.b, cmp_i.fmt);
    key_a    = fp_order_key(cmp_i.a, cmp_i.fmt);
    key_b    = fp_order_key(cmp_i.b, cmp_i.fmt);
    b_wins   = 1'b0;
    both_nan = 1'b0;

    if (cmp_i.a_valid && cmp_i.b_valid) begin
      if (a_nan && b_nan)  both_nan = 1'b1;
      else if (a_nan)      b_wins   = 1'b1;
      else if (b_nan)      b_wins   = 1'b0;
      // Strict compare: equal keys keep the left (lower-index) operand.
      else                 b_wins   = cmp_i.op ? (key_a < key_b) : (key_b < key_a);
    end else begin
      b_wins = cmp_i.b_valid;
    end

    sel_res = b_wins ? cmp_i.b     : cmp_i.a;
    sel_idx = b_wins ? cmp_i.idx_b : cmp_i.idx_a;
    sel_nan = both_nan | (b_wins ? b_nan : a_nan);

    cmp_o.valid = cmp_i.a_valid | cmp_i.b_valid;
    cmp_o.nv    = (cmp_i.a_valid & a_snan) | (cmp_i.b_valid & b_snan);
    cmp_o.res   = '0;
    cmp_o.idx   = '0;
    if (cmp_o.valid) begin
      if (sel_nan) begin
        cmp_o.res = fp_cnan(cmp_i.fmt);
        cmp_o.idx = '1;
      end else begin
        cmp_o.res = cmp_i.fmt ? sel_res : {32'b0, sel_res[31:0]};
        cmp_o.idx = sel_idx;
      end
    end
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// rtl/fp_minmax_reduce.sv - streaming masked min/max reduction with arg index and NV flag
module fp_minmax_reduce
  import fp_wire::*;
#(
  parameter int LANES = 4,
  parameter int IDXW  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*LANES-1:0]   in_data,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  in_last,
  input  logic                  in_fmt,
  input  logic                  in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_result,
  output logic [IDXW-1:0]       out_index,
  output logic [4:0]            out_flags
);

  localparam int LOG2L = $clog2(LANES);
  localparam int EW    = IDXW + LOG2L + 1;

  fp_mmr_state_t     state_q, state_d;
  logic              fmt_q, op_q, acc_valid_q, nv_q;
  logic [IDXW-1:0]   beat_cnt_q, acc_idx_q, out_index_q;
  logic [63:0]       acc_res_q, out_result_q;
  logic [4:0]        out_flags_q;

  logic              accept, first, eff_fmt, eff_op, acc_valid_cur, nv_cur, nv_next;
  logic [IDXW-1:0]   cnt_cur, cnt_next;
  fp_mm_cmp_out_type root, merge_o;
  fp_mm_cmp_in_type  merge_i;
  logic              unused_idx;

  assign in_ready = (state_q != DONE) | out_ready;
  assign accept   = in_valid & in_ready;
  // Any beat accepted outside ACC opens a fresh reduction (IDLE, or DONE while draining).
  assign first    = (state_q != ACC);

  assign eff_fmt       = first ? in_fmt : fmt_q;
  assign eff_op        = first ? in_op  : op_q;
  assign acc_valid_cur = first ? 1'b0   : acc_valid_q;
  assign nv_cur        = first ? 1'b0   : nv_q;
  assign cnt_cur       = first ? '0     : beat_cnt_q;
  assign cnt_next      = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;

  for (genvar l = 0; l <= LOG2L; l++) begin : g_lvl
    fp_mm_cmp_out_type node [LANES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [EW-1:0]   elem;
        logic [IDXW-1:0] elem_idx;
        assign elem     = EW'(cnt_cur) * EW'(LANES) + EW'(i);
        assign elem_idx = (elem > EW'({IDXW{1'b1}})) ? '1 : elem[IDXW-1:0];
        assign node[i]  = '{res: in_data[64*i +: 64], idx: FP_MM_IDX_W'(elem_idx),
                            valid: in_mask[i], nv: 1'b0};
      end
    end else begin : g_tree
      for (genvar j = 0; j < (LANES >> l); j++) begin : g_node
        fp_mm_cmp_out_type lhs, rhs, cout;
        fp_mm_cmp_in_type  cin;
        assign lhs = g_lvl[l-1].node[2*j];
        assign rhs = g_lvl[l-1].node[2*j+1];
        assign cin = '{a: lhs.res, b: rhs.res, idx_a: lhs.idx, idx_b: rhs.idx,
                       fmt: eff_fmt, op: eff_op, a_valid: lhs.valid, b_valid: rhs.valid};
        fp_mm_cmp u_cmp (.cmp_i(cin), .cmp_o(cout));
        assign node[j] = '{res: cout.res, idx: cout.idx, valid: cout.valid,
                           nv: cout.nv | lhs.nv | rhs.nv};
      end
    end
  end

  assign root = g_lvl[LOG2L].node[0];

  // Accumulator is the left operand so earlier elements win ties.
  assign merge_i = '{a: acc_res_q, b: root.res, idx_a: FP_MM_IDX_W'(acc_idx_q), idx_b: root.idx,
                     fmt: eff_fmt, op: eff_op, a_valid: acc_valid_cur, b_valid: root.valid};

  fp_mm_cmp u_merge (.cmp_i(merge_i), .cmp_o(merge_o));

  assign nv_next    = nv_cur | root.nv | merge_o.nv;
  assign unused_idx = ^merge_o.idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: if (accept) state_d = in_last ? DONE : ACC;
      DONE: begin
        if (accept)         state_d = in_last ? DONE : ACC;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fmt_q        <= 1'b0;
      op_q         <= 1'b0;
      beat_cnt_q   <= '0;
      acc_valid_q  <= 1'b0;
      acc_res_q    <= '0;
      acc_idx_q    <= '0;
      nv_q         <= 1'b0;
      out_result_q <= '0;
      out_index_q  <= '0;
      out_flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fmt_q       <= eff_fmt;
        op_q        <= eff_op;
        beat_cnt_q  <= cnt_next;
        acc_valid_q <= merge_o.valid;
        acc_res_q   <= merge_o.res;
        acc_idx_q   <= merge_o.idx[IDXW-1:0];
        nv_q        <= nv_next;
        if (in_last) begin
          // An empty reduction reports canonical NaN with the all-ones index.
          out_result_q <= merge_o.valid ? merge_o.res : fp_cnan(eff_fmt);
          out_index_q  <= merge_o.valid ? merge_o.idx[IDXW-1:0] : '1;
          out_flags_q  <= {nv_next, 4'b0};
        end
      end
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_result = out_result_q;
  assign out_index  = out_index_q;
  assign out_flags  = out_flags_q;

endmodule
